// File: rtl/ex_forward_ctrl_pkg.sv
// Shared types and helpers for the EXECUTE-stage forwarding/hazard controller.
package ex_ctrl_pkg;

  localparam int RIDX_W = 4;   // register index width (16 architectural regs)
  localparam int CNT_W  = 16;  // saturating stall-cycle counter width

  // EX operand mux select: decode value, MEM-stage result or WB-stage result.
  typedef enum logic [1:0] {
    FWD_DEC = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Controller state: normal flow or the single load-use stall cycle.
  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } ctrl_state_t;

  // Register indices match unless both refer to the hardwired-zero register.
  function automatic logic reg_match(input logic [RIDX_W-1:0] a,
                                     input logic [RIDX_W-1:0] b,
                                     input logic              zero_reg);
    return (a == b) && !(zero_reg && (a == {RIDX_W{1'b0}}));
  endfunction

endpackage

// File: rtl/ex_forward_ctrl_if.sv
// Bundle between decode/pipeline control and the forwarding controller.
// The master side presents the ID instruction and pipe control; the
// slave side (the controller) returns operand selects and stall/bubble.
interface ex_forward_ctrl_if;
  import ex_ctrl_pkg::*;

  logic              id_valid;
  logic [RIDX_W-1:0] id_rs1;
  logic [RIDX_W-1:0] id_rs2;
  logic [RIDX_W-1:0] id_rst;
  logic              id_use1;
  logic              id_use2;
  logic              id_use_st;
  logic [RIDX_W-1:0] id_rd;
  logic              id_we;
  logic              id_is_load;
  logic              flush;
  logic              mem_busy;

  fwd_sel_t          reg1_sel;
  fwd_sel_t          reg2_sel;
  fwd_sel_t          st_sel;
  logic              stall_id;
  logic              bubble_ex;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rst, id_use1, id_use2, id_use_st,
           id_rd, id_we, id_is_load, flush, mem_busy,
    input  reg1_sel, reg2_sel, st_sel, stall_id, bubble_ex, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rst, id_use1, id_use2, id_use_st,
           id_rd, id_we, id_is_load, flush, mem_busy,
    output reg1_sel, reg2_sel, st_sel, stall_id, bubble_ex, stall_cnt
  );

endinterface

// File: rtl/ex_forward_ctrl_fwd_sel_calc.sv
// Per-operand forwarding select: picks the youngest in-flight writer of the
// EX instruction's source register (MEM beats WB), else the decode value.
module fwd_sel_calc
  import ex_ctrl_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              ex_valid,
  input  logic              src_use,
  input  logic [RIDX_W-1:0] src,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [RIDX_W-1:0] wb_rd,
  output fwd_sel_t          sel
);

  // Priority select: no real read -> decode, MEM writer -> MEM, WB writer -> WB.
  always_comb begin
    sel = FWD_DEC;
    if (!(ex_valid && src_use)) begin
      sel = FWD_DEC;
    end else if (mem_valid && mem_we && reg_match(mem_rd, src, ZERO_REG)) begin
      sel = FWD_MEM;
    end else if (wb_valid && wb_we && reg_match(wb_rd, src, ZERO_REG)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_DEC;
    end
  end

endmodule

// File: rtl/ex_forward_ctrl.sv
// EXECUTE-stage forwarding and load-use hazard controller. Keeps a shadow
// copy of the EX/MEM/WB destination info, drives the EX operand selects and
// stalls ID for one cycle when the ID instruction needs a load still in EX.
module ex_forward_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_forward_ctrl_if.slave   bus
);

  // EX shadow stage (full source info is needed for select computation)
  logic              ex_valid_r;
  logic [RIDX_W-1:0] ex_rs1_r;
  logic [RIDX_W-1:0] ex_rs2_r;
  logic [RIDX_W-1:0] ex_rst_r;
  logic              ex_use1_r;
  logic              ex_use2_r;
  logic              ex_use_st_r;
  logic [RIDX_W-1:0] ex_rd_r;
  logic              ex_we_r;
  logic              ex_load_r;
  // MEM and WB shadow stages only need the writer identity
  logic              mem_valid_r;
  logic [RIDX_W-1:0] mem_rd_r;
  logic              mem_we_r;
  logic              wb_valid_r;
  logic [RIDX_W-1:0] wb_rd_r;
  logic              wb_we_r;

  ctrl_state_t       state_r;
  ctrl_state_t       state_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              src_hit_s;
  logic              hazard_s;
  logic              stall_id_s;
  logic              bubble_ex_s;
  logic              take_id_s;
  fwd_sel_t          reg1_sel_s;
  fwd_sel_t          reg2_sel_s;
  fwd_sel_t          st_sel_s;

  // Load-use detection: a load in EX whose destination is read by the ID instruction.
  always_comb begin
    src_hit_s = (bus.id_use1   && reg_match(ex_rd_r, bus.id_rs1, ZERO_REG)) ||
                (bus.id_use2   && reg_match(ex_rd_r, bus.id_rs2, ZERO_REG)) ||
                (bus.id_use_st && reg_match(ex_rd_r, bus.id_rst, ZERO_REG));
    hazard_s  = bus.id_valid && ex_valid_r && ex_we_r && ex_load_r && src_hit_s;
  end

  // Control FSM: next state plus stall/bubble decisions; busy freezes everything, flush wins over a hazard.
  always_comb begin
    state_nxt_s = state_r;
    stall_id_s  = 1'b0;
    bubble_ex_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.mem_busy) begin
          stall_id_s = 1'b1;
        end else if (bus.flush) begin
          bubble_ex_s = 1'b1;
        end else if (hazard_s) begin
          stall_id_s  = 1'b1;
          bubble_ex_s = 1'b1;
          state_nxt_s = LU_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LU_STALL: begin
        // EX holds the inserted bubble here, so no hazard can be re-raised
        if (bus.mem_busy) begin
          stall_id_s = 1'b1;
        end else begin
          bubble_ex_s = bus.flush;
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
    take_id_s = bus.id_valid && !stall_id_s && !bus.flush;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shadow pipe: shifts on every non-busy cycle, EX takes the ID instruction or a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_r  <= 1'b0;
      ex_rs1_r    <= {RIDX_W{1'b0}};
      ex_rs2_r    <= {RIDX_W{1'b0}};
      ex_rst_r    <= {RIDX_W{1'b0}};
      ex_use1_r   <= 1'b0;
      ex_use2_r   <= 1'b0;
      ex_use_st_r <= 1'b0;
      ex_rd_r     <= {RIDX_W{1'b0}};
      ex_we_r     <= 1'b0;
      ex_load_r   <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_rd_r    <= {RIDX_W{1'b0}};
      mem_we_r    <= 1'b0;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= {RIDX_W{1'b0}};
      wb_we_r     <= 1'b0;
    end else if (!bus.mem_busy) begin
      wb_valid_r  <= mem_valid_r;
      wb_rd_r     <= mem_rd_r;
      wb_we_r     <= mem_we_r;
      mem_valid_r <= ex_valid_r;
      mem_rd_r    <= ex_rd_r;
      mem_we_r    <= ex_we_r;
      if (take_id_s) begin
        ex_valid_r  <= 1'b1;
        ex_rs1_r    <= bus.id_rs1;
        ex_rs2_r    <= bus.id_rs2;
        ex_rst_r    <= bus.id_rst;
        ex_use1_r   <= bus.id_use1;
        ex_use2_r   <= bus.id_use2;
        ex_use_st_r <= bus.id_use_st;
        ex_rd_r     <= bus.id_rd;
        ex_we_r     <= bus.id_we;
        ex_load_r   <= bus.id_is_load;
      end else begin
        ex_valid_r  <= 1'b0;
        ex_rs1_r    <= {RIDX_W{1'b0}};
        ex_rs2_r    <= {RIDX_W{1'b0}};
        ex_rst_r    <= {RIDX_W{1'b0}};
        ex_use1_r   <= 1'b0;
        ex_use2_r   <= 1'b0;
        ex_use_st_r <= 1'b0;
        ex_rd_r     <= {RIDX_W{1'b0}};
        ex_we_r     <= 1'b0;
        ex_load_r   <= 1'b0;
      end
    end
  end

  // Saturating count of cycles spent with ID stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_id_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end
  end

  fwd_sel_calc #(.ZERO_REG(ZERO_REG)) u_sel_rs1 (
    .ex_valid (ex_valid_r), .src_use (ex_use1_r), .src (ex_rs1_r),
    .mem_valid(mem_valid_r), .mem_we (mem_we_r), .mem_rd (mem_rd_r),
    .wb_valid (wb_valid_r), .wb_we (wb_we_r), .wb_rd (wb_rd_r),
    .sel      (reg1_sel_s)
  );

  fwd_sel_calc #(.ZERO_REG(ZERO_REG)) u_sel_rs2 (
    .ex_valid (ex_valid_r), .src_use (ex_use2_r), .src (ex_rs2_r),
    .mem_valid(mem_valid_r), .mem_we (mem_we_r), .mem_rd (mem_rd_r),
    .wb_valid (wb_valid_r), .wb_we (wb_we_r), .wb_rd (wb_rd_r),
    .sel      (reg2_sel_s)
  );

  fwd_sel_calc #(.ZERO_REG(ZERO_REG)) u_sel_st (
    .ex_valid (ex_valid_r), .src_use (ex_use_st_r), .src (ex_rst_r),
    .mem_valid(mem_valid_r), .mem_we (mem_we_r), .mem_rd (mem_rd_r),
    .wb_valid (wb_valid_r), .wb_we (wb_we_r), .wb_rd (wb_rd_r),
    .sel      (st_sel_s)
  );

  assign bus.reg1_sel  = reg1_sel_s;
  assign bus.reg2_sel  = reg2_sel_s;
  assign bus.st_sel    = st_sel_s;
  assign bus.stall_id  = stall_id_s;
  assign bus.bubble_ex = bubble_ex_s;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Randomized self-checking bench for ex_forward_ctrl. The reference model
// keeps the in-flight instructions as a three-slot array (EX, MEM, WB) and
// derives selects, stall and bubble directly from the forwarding rules.
module tb_ex_forward_ctrl;
  import ex_ctrl_pkg::*;

  typedef struct packed {
    logic             valid;
    logic [2:0][3:0]  rs;       // [0]=rs1 [1]=rs2 [2]=store-data source
    logic [2:0]       use_src;
    logic [3:0]       rd;
    logic             we;
    logic             load;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_forward_ctrl_if bus_if ();

  ex_forward_ctrl #(.ZERO_REG(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  slot_t       pipe [3];     // 0=EX, 1=MEM, 2=WB; a stage index doubles as its select code
  slot_t       id_s;
  int          vec_cnt      = 0;
  int          miscompare_cnt = 0;
  int unsigned exp_cnt;
  int          busy_left;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit same_reg(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && (a != 4'd0);
  endfunction

  // Youngest producer of the EX operand k, searching MEM then WB.
  function automatic int exp_sel(input int k);
    if (!pipe[0].valid || !pipe[0].use_src[k]) return 0;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].valid && pipe[s].we && same_reg(pipe[s].rd, pipe[0].rs[k])) return s;
    return 0;
  endfunction

  function automatic bit exp_hazard(input slot_t id);
    if (!(id.valid && pipe[0].valid && pipe[0].we && pipe[0].load)) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (id.use_src[k] && same_reg(pipe[0].rd, id.rs[k])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid = ($urandom_range(0, 9) != 0);
    for (int k = 0; k < 3; k++) begin
      s.rs[k]      = 4'($urandom_range(0, 3));
      s.use_src[k] = ($urandom_range(0, 9) < 6);
    end
    s.rd   = 4'($urandom_range(0, 3));
    s.load = ($urandom_range(0, 9) < 3);
    s.we   = s.load ? 1'b1 : ($urandom_range(0, 9) < 8);
    return s;
  endfunction

  task automatic drive(input slot_t s, input logic fl, input logic busy);
    bus_if.id_valid   = s.valid;
    bus_if.id_rs1     = s.rs[0];
    bus_if.id_rs2     = s.rs[1];
    bus_if.id_rst     = s.rs[2];
    bus_if.id_use1    = s.use_src[0];
    bus_if.id_use2    = s.use_src[1];
    bus_if.id_use_st  = s.use_src[2];
    bus_if.id_rd      = s.rd;
    bus_if.id_we      = s.we;
    bus_if.id_is_load = s.load;
    bus_if.flush      = fl;
    bus_if.mem_busy   = busy;
  endtask

  initial begin
    logic fl, busy, haz, stall_e, bubble_e;
    rst_n = 1'b0;
    drive(slot_t'(0), 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) pipe[s] = slot_t'(0);
    exp_cnt   = 0;
    busy_left = 0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      id_s  = rand_slot();
      fl    = ($urandom_range(0, 9) == 0);
      if (busy_left > 0) begin
        busy = 1'b1;
        busy_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        busy      = 1'b1;
        busy_left = $urandom_range(0, 3);
      end else begin
        busy = 1'b0;
      end
      drive(id_s, fl, busy);
      #1;

      haz      = exp_hazard(id_s);
      stall_e  = busy || (haz && !fl);
      bubble_e = !busy && (haz || fl);
      check_val("reg1_sel",  32'(bus_if.reg1_sel),  32'(exp_sel(0)));
      check_val("reg2_sel",  32'(bus_if.reg2_sel),  32'(exp_sel(1)));
      check_val("st_sel",    32'(bus_if.st_sel),    32'(exp_sel(2)));
      check_val("stall_id",  32'(bus_if.stall_id),  32'(stall_e));
      check_val("bubble_ex", 32'(bus_if.bubble_ex), 32'(bubble_e));
      check_val("stall_cnt", 32'(bus_if.stall_cnt), exp_cnt);

      // State the design should hold after the coming rising edge
      if (!rst_n) begin
        for (int s = 0; s < 3; s++) pipe[s] = slot_t'(0);
        exp_cnt = 0;
      end else begin
        if (stall_e && exp_cnt != 32'd65535) exp_cnt++;
        if (!busy) begin
          pipe[2] = pipe[1];
          pipe[1] = pipe[0];
          pipe[0] = (id_s.valid && !stall_e && !fl) ? id_s : slot_t'(0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
